counter_sec: RTL and testbench
==============================

Name: counter_sec

Overview:
- Modulo-60 seconds counter for the digital-clock datapath.
- Counts on each enabled clock edge and supports synchronous parallel load.
- Asserts carry_sec in the cycle it wraps 59->0; this drives the enable of the downstream minutes counter.
- Leaf block, single clock domain.

Parameters:
- WIDTH, 6, bit width of data_sec and count_sec.
- MAX_COUNT, 59, terminal count; the counter wraps from MAX_COUNT to 0. Must be < 2**WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_sec  input  1  asynchronous, active-low reset; low clears the counter immediately.
- data_sec  input  WIDTH  parallel load value.
- load_sec  input  1  synchronous load strobe, active-high.
- enable_sec  input  1  count enable, active-high.
- count_sec  output  WIDTH  current count, registered.
- carry_sec  output  1  terminal-count carry, combinational.

Behaviour:
- Reset: reset_sec low forces count_sec=0 asynchronously, regardless of clock. While reset_sec is low, carry_sec=0.
- Release: counting resumes on the first rising edge after reset_sec goes high. No synchronizer inside the block.
- Priority at each rising edge (reset_sec high): load_sec > enable_sec > hold.
- Load: load_sec=1 sets count_sec <= data_sec, independent of enable_sec.
  - If data_sec > MAX_COUNT, count_sec <= 0 (out-of-range loads clamp to zero).
- Count: load_sec=0, enable_sec=1:
  - count_sec <= count_sec+1 when count_sec < MAX_COUNT.
  - count_sec <= 0 when count_sec == MAX_COUNT.
- Hold: load_sec=0, enable_sec=0 keeps count_sec unchanged.
- carry_sec = (count_sec==MAX_COUNT) & enable_sec & ~load_sec & reset_sec.
  - Combinational, high for exactly the one cycle that precedes the wrap edge.
  - Downstream stages sample it on the same edge as the wrap.
- Increment latency: one clock. Load latency: one clock. carry_sec has zero-cycle latency from its inputs.
- enable_sec dropping while count_sec==MAX_COUNT: carry_sec drops immediately, count holds at MAX_COUNT, and carry_sec reasserts when enable_sec returns.
- Load of MAX_COUNT with enable_sec=1: carry_sec is low during the load cycle and high in the following cycle.
- Reset mid-count: count_sec clears immediately. No pending wrap or carry survives reset.
- Internal state never holds a value > MAX_COUNT.

Optional Feature:
- Macro: COUNTER_SEC_BCD_EN.
- When defined, two extra outputs are added:
  - bcd_tens_sec, output, 3 bits.
  - bcd_units_sec, output, 4 bits.
- These are registered BCD digits of count_sec (e.g. 47 -> 4,7). They are updated in the same edge as count_sec, are equal to 0,0 on reset, and follow load, clamp and wrap identically. The display drives them directly without a divider.
- When not defined, those ports and their logic are absent. Binary behaviour is identical in both builds.

Test Plan:
- Hold reset_sec low 10 ns with enable_sec=1, then release -> count_sec=0 during reset; reaches 1 on the first rising edge after release, then increments every cycle.
- Run enable_sec=1 from 0 -> count_sec 58,59,0,1. carry_sec=1 only while count_sec=59; never at other values.
- Drop enable_sec for 10 cycles at count 20 -> count_sec holds at 20 and carry_sec stays 0; restore enable_sec -> 21 next edge.
- Pulse load_sec with data_sec=45, enable_sec=1 -> count_sec=45 next edge, then 46. Pulse load_sec with data_sec=63 -> count_sec=0.
- Load 59 with enable_sec=0 -> carry_sec=0. Raise enable_sec -> carry_sec=1; next edge count_sec=0 and carry_sec=0.
- Assert reset_sec low mid-cycle at count 33 -> count_sec=0 before the next clock edge and carry_sec=0. With COUNTER_SEC_BCD_EN defined, count 47 gives tens=4, units=7.

Source files
------------

// File: rtl/counter_sec.sv
// Modulo-60 seconds counter with synchronous load and wrap carry.
// Define COUNTER_SEC_BCD_EN to add registered BCD digit outputs.
module counter_sec #(
    parameter int WIDTH     = 6,
    parameter int MAX_COUNT = 59
) (
    input  logic             clock,
    input  logic             reset_sec,
    input  logic [WIDTH-1:0] data_sec,
    input  logic             load_sec,
    input  logic             enable_sec,
    output logic [WIDTH-1:0] count_sec,
    output logic             carry_sec
`ifdef COUNTER_SEC_BCD_EN
    ,
    output logic [2:0]       bcd_tens_sec,
    output logic [3:0]       bcd_units_sec
`endif
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             load_oor;

    assign at_max   = (count_q == MAX_Q);
    assign load_oor = (data_sec > MAX_Q);

    always_comb begin
        count_d = count_q;
        if (load_sec) begin
            count_d = load_oor ? '0 : data_sec;
        end else if (enable_sec) begin
            count_d = at_max ? '0 : count_q + ONE_Q;
        end
    end

    always_ff @(posedge clock or negedge reset_sec) begin
        if (!reset_sec) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_sec = count_q;
    // Gated by reset so the carry drops the instant reset asserts.
    assign carry_sec = at_max & enable_sec & ~load_sec & reset_sec;

`ifdef COUNTER_SEC_BCD_EN
    logic [2:0] tens_q;
    logic [2:0] tens_d;
    logic [3:0] units_q;
    logic [3:0] units_d;

    // Digits track the binary count step for step, so no divider on the count path.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (load_sec) begin
            if (load_oor) begin
                tens_d  = '0;
                units_d = '0;
            end else begin
                tens_d  = 3'(data_sec / 10);
                units_d = 4'(data_sec % 10);
            end
        end else if (enable_sec) begin
            if (at_max) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 3'd1;
                units_d = '0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_sec) begin
        if (!reset_sec) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign bcd_tens_sec  = tens_q;
    assign bcd_units_sec = units_q;
`endif

endmodule

// File: tb/tb_counter_sec.sv
// Scoreboard bench for counter_sec: stimulus pushes expectations,
// a monitor pops and compares them on the falling edge.
module tb_counter_sec;

    logic       clock;
    logic       reset_sec;
    logic [5:0] data_sec;
    logic       load_sec;
    logic       enable_sec;
    logic [5:0] count_sec;
    logic       carry_sec;
`ifdef COUNTER_SEC_BCD_EN
    logic [2:0] bcd_tens_sec;
    logic [3:0] bcd_units_sec;
`endif

    typedef struct {
        int   row;
        logic [5:0] cnt;
        logic       cry;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int row_n  = 0;
    bit done   = 0;

    counter_sec #(.WIDTH(6), .MAX_COUNT(59)) dut (
        .clock(clock),
        .reset_sec(reset_sec),
        .data_sec(data_sec),
        .load_sec(load_sec),
        .enable_sec(enable_sec),
        .count_sec(count_sec),
        .carry_sec(carry_sec)
`ifdef COUNTER_SEC_BCD_EN
        ,
        .bcd_tens_sec(bcd_tens_sec),
        .bcd_units_sec(bcd_units_sec)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs just after a rising edge; expected values are what the
    // DUT must show for the rest of that cycle.
    task automatic step(input logic rst, input logic ld, input logic en,
                        input logic [5:0] d, input logic [5:0] ec,
                        input logic ey);
        exp_t e;
        @(posedge clock);
        #1;
        reset_sec  = rst;
        load_sec   = ld;
        enable_sec = en;
        data_sec   = d;
        row_n++;
        e.row = row_n;
        e.cnt = ec;
        e.cry = ey;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (count_sec !== e.cnt) begin
                    errors++;
                    $display("FAIL count row %0d: got %0d want %0d",
                             e.row, count_sec, e.cnt);
                end
                checks++;
                if (carry_sec !== e.cry) begin
                    errors++;
                    $display("FAIL carry row %0d: got %0b want %0b",
                             e.row, carry_sec, e.cry);
                end
`ifdef COUNTER_SEC_BCD_EN
                checks++;
                if (bcd_tens_sec !== 3'(e.cnt / 10) ||
                    bcd_units_sec !== 4'(e.cnt % 10)) begin
                    errors++;
                    $display("FAIL bcd row %0d: got %0d,%0d want %0d,%0d",
                             e.row, bcd_tens_sec, bcd_units_sec,
                             e.cnt / 10, e.cnt % 10);
                end
`endif
            end
        end
    end

    initial begin : stim
        reset_sec  = 1'b0;
        load_sec   = 1'b0;
        enable_sec = 1'b1;
        data_sec   = '0;
        // reset held, then release and count up
        step(0, 0, 1, 0,  0, 0);
        step(1, 0, 1, 0,  0, 0);
        step(1, 0, 1, 0,  1, 0);
        step(1, 0, 1, 0,  2, 0);
        step(1, 0, 1, 0,  3, 0);
        step(1, 0, 1, 0,  4, 0);
        // jump near the top and wrap
        step(1, 1, 1, 57, 5, 0);
        step(1, 0, 1, 0, 57, 0);
        step(1, 0, 1, 0, 58, 0);
        step(1, 0, 1, 0, 59, 1);
        step(1, 0, 1, 0,  0, 0);
        step(1, 0, 1, 0,  1, 0);
        // hold at 20 for ten cycles
        step(1, 1, 0, 20, 2, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 20, 0);
        step(1, 0, 1, 0, 20, 0);
        step(1, 0, 1, 0, 21, 0);
        // load 45, then out-of-range 63 clamps
        step(1, 1, 1, 45, 22, 0);
        step(1, 0, 1, 0, 45, 0);
        step(1, 1, 1, 63, 46, 0);
        step(1, 0, 0, 0,  0, 0);
        // load 59 with enable low, then enable
        step(1, 1, 0, 59, 0, 0);
        step(1, 0, 0, 0, 59, 0);
        step(1, 0, 1, 0, 59, 1);
        step(1, 0, 1, 0,  0, 0);
        // load 59 with enable high; load at 59 masks carry
        step(1, 1, 1, 59, 1, 0);
        step(1, 1, 1, 59, 59, 0);
        step(1, 0, 0, 0, 59, 0);
        step(1, 0, 1, 0, 59, 1);
        // BCD sample 47, then reset mid-cycle at 33
        step(1, 1, 1, 47, 0, 0);
        step(1, 1, 1, 33, 47, 0);
        step(1, 0, 0, 0, 33, 0);
        step(0, 0, 1, 0,  0, 0);
        step(0, 0, 1, 0,  0, 0);
        step(1, 0, 1, 0,  0, 0);
        step(1, 0, 1, 0,  1, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
